// File: rtl/dmux_rr_dispatch_if.sv
// rtl/dmux_rr_dispatch_if.sv - stream-in / select-out bundle between the dispatch stage and its neighbours
`timescale 1ns/1ps
interface dmux_rr_dispatch_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic [3:0]         out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         sel;
  logic [COUNT_W-1:0] count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, count
  );
endinterface

// File: rtl/dmux_rr_dispatch.sv
// rtl/dmux_rr_dispatch.sv - one-word round-robin dispatch stage feeding a 1-to-4 demux
// Define RR_SKIP_EN to let the destination skip past consumers not ready at accept time.
`timescale 1ns/1ps
module dmux_rr_dispatch #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  dmux_rr_dispatch_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic       out_valid;
  logic       fire;
  logic       in_ready;
  logic       accept;
  logic [1:0] base;
  logic [1:0] dest;
`ifdef RR_SKIP_EN
  logic [1:0] idx;
  logic       found;
`endif

  always_comb begin
    out_valid = (state_q == FULL);
    fire      = out_valid & bus.out_ready[sel_q];
    in_ready  = ~out_valid | fire;
    accept    = bus.in_valid & in_ready;
    // A word accepted in the same cycle as a fire must see the advanced pointer.
    base      = fire ? (sel_q + 2'd1) : ptr_q;
  end

  always_comb begin
    dest = base;
`ifdef RR_SKIP_EN
    idx   = base;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && bus.out_ready[idx]) begin
        dest  = idx;
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    count_d = count_q;

    if (fire) begin
      ptr_d   = sel_q + 2'd1;
      count_d = count_q + 1'b1;
    end

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (fire && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      data_d = bus.in_data;
      sel_d  = dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_dmux_rr_dispatch.sv
// tb/tb_dmux_rr_dispatch.sv - directed and random checks of dmux_rr_dispatch against a word-level model
`timescale 1ns/1ps
module tb_dmux_rr_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmux_rr_dispatch_if #(.WIDTH(8), .COUNT_W(16)) bus ();
  dmux_rr_dispatch_if #(.WIDTH(8), .COUNT_W(4))  bus4 ();

  // The narrow-counter instance sees exactly the same traffic.
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.out_ready = bus.out_ready;

  dmux_rr_dispatch #(.WIDTH(8), .COUNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  dmux_rr_dispatch #(.WIDTH(8), .COUNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int tests = 0;
  int fails = 0;

  bit m_full;
  int m_data, m_sel, m_ptr, m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
`ifdef RR_SKIP_EN
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_count = 0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input logic [3:0] r, input string tag);
    bit f, acc;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(negedge clk);
    f   = m_full && r[m_sel];
    acc = v && (!m_full || f);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(!m_full || f));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_full));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".sel"},       32'(bus.sel),       32'(m_sel));
    chk({tag, ".count"},     32'(bus.count),     32'(m_count % 65536));
    chk({tag, ".count4"},    32'(bus4.count),    32'(m_count % 16));
    @(posedge clk);
    if (f) begin
      m_ptr = (m_sel + 1) % 4;
      m_count++;
    end
    if (acc) begin
      m_data = d;
      m_sel  = pick(m_ptr, r);
      m_full = 1;
    end else if (f) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic reset_dut(input string tag);
    bus.in_valid  = 0;
    bus.in_data   = 0;
    bus.out_ready = 0;
    rst = 1;
    #1;
    chk({tag, ".rst_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".rst_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, ".rst_sel"},       32'(bus.sel),       32'd0);
    chk({tag, ".rst_count"},     32'(bus.count),     32'd0);
    chk({tag, ".rst_count4"},    32'(bus4.count),    32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    bus.in_valid  = 0;
    bus.in_data   = 0;
    bus.out_ready = 0;

    reset_dut("init");

    // Back-to-back words with every consumer ready.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hA0 + 8'(i), 4'b1111, "t1");
    cycle(1'b0, 8'h00, 4'b1111, "t1d");
    chk("t1.count8", 32'(bus.count), 32'd8);

    // Stall on sel=0 with only other consumers ready.
    cycle(1'b1, 8'h55, 4'b1111, "t2a");
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 4'b1110, "t2s");
    chk("t2.sel",      32'(bus.sel),      32'd0);
    chk("t2.data",     32'(bus.out_data), 32'h55);
    chk("t2.in_ready", 32'(bus.in_ready), 32'd0);
    chk("t2.count",    32'(bus.count),    32'd8);
    cycle(1'b0, 8'h00, 4'b0001, "t2f");
    chk("t2.count9",   32'(bus.count),    32'd9);

    // ptr=1, consumers 0 and 3 ready at accept.
    cycle(1'b1, 8'h77, 4'b1001, "t3a");
`ifdef RR_SKIP_EN
    chk("t3.sel", 32'(bus.sel), 32'd3);
`else
    chk("t3.sel", 32'(bus.sel), 32'd1);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 4'b1001, "t3s");
    cycle(1'b0, 8'h00, 4'b0010, "t3f");
    cycle(1'b0, 8'h00, 4'b0000, "t3e");

    // Reset while holding a word.
    cycle(1'b1, 8'h3C, 4'b0000, "t4a");
    cycle(1'b0, 8'h00, 4'b0000, "t4h");
    #2;
    reset_dut("t4");
    cycle(1'b1, 8'h11, 4'b1111, "t4n");
    chk("t4.sel_after", 32'(bus.sel), 32'd0);
    cycle(1'b0, 8'h00, 4'b1111, "t4d");

    // Counter wrap on the 4-bit instance.
    reset_dut("t5");
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 4'b1111, "t5");
    cycle(1'b0, 8'h00, 4'b1111, "t5d");
    chk("t5.count4", 32'(bus4.count), 32'd1);
    chk("t5.count",  32'(bus.count),  32'd17);

    // Idle gap mid-stream.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 4'b1111, "t6a");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 4'b1111, "t6g");
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hD0 + 8'(i), 4'b1111, "t6b");
    cycle(1'b0, 8'h00, 4'b1111, "t6d");

    // Random traffic with random per-consumer readiness.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), "rnd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
